fifo_drain_serializer: RTL and testbench

- Read-side consumer for the team's synchronous FIFO (the FIFO's write side is driven by upstream logic).
- Pops N-bit words from the FIFO, one at a time, whenever the FIFO is non-empty and transmission is enabled.
- Shifts each word out as an asynchronous-serial frame, LSB first: start bit, N data bits, optional parity bit, stop bit.
- Sits between the FIFO read port and a single-wire serial output pin.

---
 rtl/fifo_ser_pkg.sv | 19 +
 rtl/fifo_drain_serializer_if.sv | 12 +
 rtl/fifo_ser_bit_timer.sv | 35 +++
 rtl/fifo_drain_serializer.sv | 122 ++++++++++++
 tb/tb_fifo_drain_serializer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_ser_pkg.sv
// rtl/fifo_ser_pkg.sv - state encoding and line levels for the FIFO drain serializer; FIFO_SER_PARITY_EN adds the PARITY state
package fifo_ser_pkg;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef FIFO_SER_PARITY_EN
        PARITY,
`endif
        STOP
    } ser_state_t;

endpackage

// File: rtl/fifo_drain_serializer_if.sv
// rtl/fifo_drain_serializer_if.sv - FIFO read-port bundle between the synchronous FIFO and the serializer
interface fifo_drain_serializer_if #(
    parameter int N = 8
);
    logic         fifo_empty;
    logic [N-1:0] fifo_data;
    logic         fifo_rd_en;

    // master is the consumer that issues pops; slave is the FIFO read side
    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_ser_bit_timer.sv
// rtl/fifo_ser_bit_timer.sv - per-bit cycle counter; flags the last and next-to-last cycle of each serial bit
module fifo_ser_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic bit_end_o,
    output logic bit_pre_end_o
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside bit states, so every bit state starts from a clean count
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o     = en_i && (cnt_q == LAST);
    assign bit_pre_end_o = en_i && (cnt_q == PRE);
endmodule

// File: rtl/fifo_drain_serializer.sv
// rtl/fifo_drain_serializer.sv - pops FIFO words and sends them LSB-first as start/data/[parity]/stop frames (FIFO_SER_PARITY_EN)
module fifo_drain_serializer
    import fifo_ser_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_enable,
    fifo_drain_serializer_if.master fif,
    output logic                    serial_out,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);

    ser_state_t       state_q;
    logic [N-1:0]     shift_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             serial_q;
    logic             done_q;
    logic             bit_end;
    logic             bit_pre_end;
    logic             in_bit;
`ifdef FIFO_SER_PARITY_EN
    logic             parity_q;
`endif

    // Gated by rst_n so no pop can be issued while the block is held in reset
    assign fif.fifo_rd_en = rst_n && (state_q == IDLE) && tx_enable && !fif.fifo_empty;
    assign in_bit         = (state_q != IDLE) && (state_q != LOAD);

    fifo_ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (in_bit),
        .bit_end_o     (bit_end),
        .bit_pre_end_o (bit_pre_end)
    );

    // serial_q is loaded with the level of the state being entered, so the pin is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            serial_q  <= IDLE_LEVEL;
            done_q    <= 1'b0;
`ifdef FIFO_SER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fif.fifo_rd_en) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q  <= fif.fifo_data;
`ifdef FIFO_SER_PARITY_EN
                    parity_q <= ^fif.fifo_data;
`endif
                    serial_q <= START_BIT;
                    state_q  <= START;
                end
                START: begin
                    if (bit_end) begin
                        serial_q <= shift_q[0];
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
`ifdef FIFO_SER_PARITY_EN
                            serial_q  <= parity_q;
                            state_q   <= PARITY;
`else
                            serial_q  <= STOP_BIT;
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            serial_q  <= shift_q[1];
                        end
                    end
                end
`ifdef FIFO_SER_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        serial_q <= STOP_BIT;
                        state_q  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_pre_end) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        serial_q <= IDLE_LEVEL;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    serial_q <= IDLE_LEVEL;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign serial_out = serial_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
endmodule

// File: tb/tb_fifo_drain_serializer.sv
// tb/tb_fifo_drain_serializer.sv - randomized scoreboard bench for fifo_drain_serializer with a FIFO model and frame reference model
module tb_fifo_drain_serializer;
    localparam int N   = 8;
    localparam int CPB = 4;
`ifdef FIFO_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (N + 2 + P) * CPB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_enable = 1'b0;
    logic         wr_en = 1'b0;
    logic [N-1:0] wr_data = '0;
    logic         fifo_empty_q = 1'b1;
    logic [N-1:0] fifo_data_q = '0;
    logic         serial_out;
    logic         busy;
    logic         frame_done;

    logic [N-1:0] fq[$];
    logic [N-1:0] exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    bit   m_active = 1'b0;
    int   m_k = 0;
    logic [N-1:0] m_word = '0;
    bit   fin_req = 1'b0;
    bit   timeout_flag = 1'b0;

    fifo_drain_serializer_if #(.N(N)) fif ();
    assign fif.fifo_empty = fifo_empty_q;
    assign fif.fifo_data  = fifo_data_q;

    fifo_drain_serializer #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_enable  (tx_enable),
        .fif        (fif.master),
        .serial_out (serial_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (fif.fifo_rd_en && fq.size() > 0) begin
            fifo_data_q <= fq.pop_front();
        end
        if (wr_en) begin
            fq.push_back(wr_data);
        end
        fifo_empty_q <= (fq.size() == 0);
    end

    task automatic cyc(input bit we, input logic [N-1:0] d);
        @(posedge clk);
        #1;
        wr_en   = we;
        wr_data = d;
        if (we) exp_q.push_back(d);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0);
    endtask

    // Expected line for cycle k after the pop strobe (k=0 is the strobe cycle or idle)
    task automatic exp_levels(input int k, input logic [N-1:0] w,
                              output logic ser, output logic bsy, output logic dn);
        int slot;
        ser = 1'b1;
        bsy = (k >= 1);
        dn  = (k == F + 1);
        if (k >= 2) begin
            slot = (k - 2) / CPB;
            if (slot == 0)                    ser = 1'b0;
            else if (slot <= N)               ser = w[slot-1];
            else if (P == 1 && slot == N + 1) ser = ^w;
            else                              ser = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc_n, act, exp);
        end
    endtask

    initial begin : monitor
        logic e_rd, e_ser, e_busy, e_done;
        forever begin
            @(negedge clk);
            if (fin_req) break;
            cyc_n++;
            if (!rst_n) begin
                m_active = 1'b0;
                e_rd = 1'b0; e_ser = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            end else begin
                if (m_active) begin
                    m_k++;
                    if (m_k > F + 1) m_active = 1'b0;
                end
                e_rd = !m_active && tx_enable && (fq.size() > 0);
                if (e_rd) begin
                    m_active = 1'b1;
                    m_k = 0;
                    chk("scoreboard_has_word", exp_q.size() > 0, 1'b1);
                    m_word = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                end
                exp_levels(m_active ? m_k : 0, m_word, e_ser, e_busy, e_done);
            end
            chk("fifo_rd_en", fif.fifo_rd_en, e_rd);
            chk("serial_out", serial_out, e_ser);
            chk("busy", busy, e_busy);
            chk("frame_done", frame_done, e_done);
        end
        chk("drain_timeout", timeout_flag, 1'b0);
        chk("scoreboard_empty", exp_q.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin : stimulus
        bit we;
        // Reset held with a non-empty FIFO and enable high: no pop, idle line
        rst_n = 1'b0;
        tx_enable = 1'b1;
        cyc(1'b1, 8'hA5);
        idle(5);
        rst_n = 1'b1;
        idle(50);
        // Back-to-back words, then an empty FIFO
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h02);
        idle(110);
        // Enable gating, and enable dropped mid-frame
        tx_enable = 1'b0;
        cyc(1'b1, 8'h3C);
        idle(20);
        tx_enable = 1'b1;
        idle(12);
        tx_enable = 1'b0;
        cyc(1'b1, 8'h11);
        idle(60);
        tx_enable = 1'b1;
        idle(55);
        // Reset mid-frame around data bit 3, then a clean frame
        cyc(1'b1, 8'h55);
        idle(19);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        cyc(1'b1, 8'h81);
        idle(55);
        // Parity-sensitive words
        cyc(1'b1, 8'h07);
        cyc(1'b1, 8'h03);
        idle(110);
        // Randomized traffic, enable toggling and occasional reset
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 19) == 0) && (fq.size() < 4);
            cyc(we, N'($urandom));
            if ($urandom_range(0, 149) == 0) tx_enable = ~tx_enable;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                idle(2);
                rst_n = 1'b1;
            end
        end
        tx_enable = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3000 && !(fq.size() == 0 && !m_active); i++) begin
            cyc(1'b0, '0);
        end
        timeout_flag = !(fq.size() == 0 && !m_active);
        idle(5);
        fin_req = 1'b1;
    end
endmodule
